// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU controller.
// Holds the opcode and FSM state enums, the ALU control word and the per-opcode control table.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_XOR = 4'd2,
    OP_OR  = 4'd3,
    OP_AND = 4'd4,
    OP_INC = 4'd5,
    OP_DEC = 4'd6,
    OP_NOT = 4'd7,
    OP_NEG = 4'd8,
    OP_SHL = 4'd9,
    OP_SHR = 4'd10,
    OP_SRA = 4'd11,
    OP_MUL = 4'd12
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic ci;
    logic nb;
    logic ic;
    logic na;
    logic xo;
    logic no;
    logic sr;
    logic ss;
  } ctrl_t;

  typedef enum logic [1:0] {
    B_REG  = 2'd0,
    B_ZERO = 2'd1,
    B_A    = 2'd2
  } bsel_e;

  localparam ctrl_t CTRL_ADD = 8'b0000_0000;

  // Bit order: ci nb ic na xo no sr ss. Opcodes 13-15 map to all-zero.
  localparam ctrl_t CTRL_TABLE [16] = '{
    8'b0000_0000,  // ADD
    8'b1100_0000,  // SUB
    8'b0010_0000,  // XOR
    8'b0010_1000,  // OR
    8'b0111_1100,  // AND
    8'b1000_0000,  // INC
    8'b0100_0000,  // DEC
    8'b0110_0000,  // NOT
    8'b1001_0000,  // NEG
    8'b0000_0000,  // SHL
    8'b0000_0010,  // SHR
    8'b0000_0011,  // SRA
    8'b0000_0000,  // MUL
    8'b0000_0000,
    8'b0000_0000,
    8'b0000_0000
  };

  function automatic logic op_legal(input logic [3:0] op);
    return (op <= 4'd12);
  endfunction

  function automatic bsel_e op_bsel(input logic [3:0] op);
    bsel_e sel;
    case (op)
      OP_INC, OP_DEC, OP_NOT, OP_NEG, OP_SHR, OP_SRA: sel = B_ZERO;
      OP_SHL:                                         sel = B_A;
      default:                                        sel = B_REG;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/alu_ctrl_alu.sv
// Combinational 16-bit ALU steered by an 8-bit control word {ci,nb,ic,na,xo,no,sr,ss}.
// Shift-right forms report the bit shifted out as carry; logic forms report zero carry.
module alu_ctrl_alu
  import alu_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [7:0]  ctrl_word,
  output logic [15:0] y,
  output logic        co
);

  ctrl_t       c_s;
  logic [15:0] a_s;
  logic [15:0] b_s;
  logic [16:0] sum_s;
  logic [15:0] base_s;

  assign c_s = ctrl_t'(ctrl_word);

  // Operand inversion, then shift, logic or add path, then optional output inversion.
  always_comb begin
    a_s    = c_s.na ? ~a : a;
    b_s    = c_s.nb ? ~b : b;
    sum_s  = {1'b0, a_s} + {1'b0, b_s} + {16'd0, c_s.ci};
    base_s = 16'd0;
    co     = 1'b0;
    if (c_s.sr) begin
      base_s = {c_s.ss & a_s[15], a_s[15:1]};
      co     = a_s[0];
    end else if (c_s.ic) begin
      base_s = c_s.xo ? (a_s | b_s) : (a_s ^ b_s);
      co     = 1'b0;
    end else begin
      base_s = sum_s[15:0];
      co     = sum_s[16];
    end
    y = c_s.no ? ~base_s : base_s;
  end

endmodule

// File: rtl/alu_ctrl.sv
// Request/response controller around the ALU: single-pass ops in EXEC,
// shift-add multiply in MUL, result held in DONE until the consumer takes it.
module alu_ctrl
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_data,
  output logic        resp_co,
  output logic        resp_err,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [15:0] opa_q, opa_d;
  logic [15:0] opb_q, opb_d;
  logic [15:0] acc_q, acc_d;
  logic [3:0]  count_q, count_d;
  logic        mul_ovf_q, mul_ovf_d;
  logic        resp_valid_q, resp_valid_d;
  logic [15:0] resp_data_q, resp_data_d;
  logic        resp_co_q, resp_co_d;
  logic        resp_err_q, resp_err_d;
  logic        req_ready_q, req_ready_d;
  logic        busy_q, busy_d;

  logic [15:0] alu_a_s;
  logic [15:0] alu_b_s;
  ctrl_t       alu_ctrl_s;
  logic [15:0] alu_y_s;
  logic        alu_co_s;

  alu_ctrl_alu u_alu (
    .a         (alu_a_s),
    .b         (alu_b_s),
    .ctrl_word (alu_ctrl_s),
    .y         (alu_y_s),
    .co        (alu_co_s)
  );

  // ALU operand and control selection: accumulate during MUL, opcode-driven otherwise.
  always_comb begin
    alu_a_s    = opa_q;
    alu_b_s    = opb_q;
    alu_ctrl_s = CTRL_TABLE[op_q];
    case (state_q)
      ST_MUL: begin
        alu_a_s    = acc_q;
        alu_b_s    = opa_q;
        alu_ctrl_s = CTRL_ADD;
      end
      ST_EXEC: begin
        case (op_bsel(op_q))
          B_ZERO:  alu_b_s = 16'd0;
          B_A:     alu_b_s = opa_q;
          default: alu_b_s = opb_q;
        endcase
      end
      default: begin
        alu_a_s = opa_q;
      end
    endcase
  end

  // Next-state and next-output logic for the controller FSM.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    acc_d        = acc_q;
    count_d      = count_q;
    mul_ovf_d    = mul_ovf_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_co_d    = resp_co_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d       = req_op;
          opa_d      = req_a;
          opb_d      = req_b;
          acc_d      = 16'd0;
          count_d    = 4'd0;
          mul_ovf_d  = 1'b0;
          resp_co_d  = 1'b0;
          resp_err_d = 1'b0;
          state_d    = (req_op == OP_MUL) ? ST_MUL : ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (op_legal(op_q)) begin
          resp_data_d = alu_y_s;
          resp_co_d   = alu_co_s;
          resp_err_d  = 1'b0;
        end else begin
          resp_data_d = 16'd0;
          resp_co_d   = 1'b0;
          resp_err_d  = 1'b1;
        end
        resp_valid_d = 1'b1;
        state_d      = ST_DONE;
      end
      ST_MUL: begin
        // Bits already shifted out of the multiplicand make this addend wrap, so they count as carry.
        if (opb_q[0]) begin
          acc_d     = alu_y_s;
          resp_co_d = resp_co_q | alu_co_s | mul_ovf_q;
        end else begin
          acc_d = acc_q;
        end
        mul_ovf_d = mul_ovf_q | opa_q[15];
        opa_d     = {opa_q[14:0], 1'b0};
        opb_d     = {1'b0, opb_q[15:1]};
        count_d   = count_q + 4'd1;
        if ((opb_q[15:1] == 15'd0) || (count_q == 4'd15)) begin
          resp_data_d  = acc_d;
          resp_err_d   = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = ST_DONE;
        end else begin
          state_d = ST_MUL;
        end
      end
      ST_DONE: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    req_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  // State and registered outputs, with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      op_q         <= 4'd0;
      opa_q        <= 16'd0;
      opb_q        <= 16'd0;
      acc_q        <= 16'd0;
      count_q      <= 4'd0;
      mul_ovf_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 16'd0;
      resp_co_q    <= 1'b0;
      resp_err_q   <= 1'b0;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      acc_q        <= acc_d;
      count_q      <= count_d;
      mul_ovf_q    <= mul_ovf_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_co_q    <= resp_co_d;
      resp_err_q   <= resp_err_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign busy       = busy_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_co    = resp_co_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Bench for alu_ctrl: an arithmetic reference model checked every cycle,
// plus directed vectors with hand-computed results and latencies.
module tb_alu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_data;
  logic        resp_co;
  logic        resp_err;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  alu_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_co    (resp_co),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] d;
    logic        c;
    logic        e;
    int          cyc;
  } res_t;

  // Reference result straight from the arithmetic meaning of each opcode.
  function automatic res_t ref_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    res_t r;
    int unsigned s;
    longint unsigned acc;
    longint unsigned t;
    r.d = 16'd0; r.c = 1'b0; r.e = 1'b0; r.cyc = 1;
    case (op)
      4'd0:  begin s = 32'(a) + 32'(b); r.d = s[15:0]; r.c = s[16]; end
      4'd1:  begin r.d = a - b; r.c = (a >= b); end
      4'd2:  r.d = a ^ b;
      4'd3:  r.d = a | b;
      4'd4:  r.d = a & b;
      4'd5:  begin r.d = a + 16'd1; r.c = (a == 16'hFFFF); end
      4'd6:  begin r.d = a - 16'd1; r.c = (a != 16'd0); end
      4'd7:  r.d = ~a;
      4'd8:  begin r.d = -a; r.c = (a == 16'd0); end
      4'd9:  begin r.d = {a[14:0], 1'b0}; r.c = a[15]; end
      4'd10: begin r.d = {1'b0, a[15:1]}; r.c = a[0]; end
      4'd11: begin r.d = {a[15], a[15:1]}; r.c = a[0]; end
      4'd12: begin
        acc = 64'd0;
        for (int i = 0; i < 16; i++) begin
          if (b[i]) begin
            t = acc + (64'(a) << i);
            if (t >= 64'd65536) r.c = 1'b1;
            acc = t & 64'hFFFF;
            r.cyc = i + 1;
          end
        end
        r.d = acc[15:0];
      end
      default: r.e = 1'b1;
    endcase
    return r;
  endfunction

  // Transaction-level model: idle -> running for the op's cycle count -> holding result.
  bit   m_idle  = 1'b1;
  bit   m_run   = 1'b0;
  bit   m_valid = 1'b0;
  int   m_cnt   = 0;
  res_t p;

  always @(posedge clk) begin
    if (rst) begin
      m_idle  <= 1'b1;
      m_run   <= 1'b0;
      m_valid <= 1'b0;
    end else if (m_idle) begin
      if (req_valid) begin
        p      <= ref_op(req_op, req_a, req_b);
        m_idle <= 1'b0;
        m_run  <= 1'b1;
        m_cnt  <= 0;
      end
    end else if (m_run) begin
      if (m_cnt + 1 == p.cyc) begin
        m_run   <= 1'b0;
        m_valid <= 1'b1;
      end
      m_cnt <= m_cnt + 1;
    end else if (m_valid && resp_ready) begin
      m_valid <= 1'b0;
      m_idle  <= 1'b1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", req_ready, m_idle);
      chk("busy", busy, !m_idle);
      chk("resp_valid", resp_valid, m_valid);
      if (m_valid) begin
        chk("resp_data", resp_data, p.d);
        chk("resp_co", resp_co, p.c);
        chk("resp_err", resp_err, p.e);
      end
    end
  end

  // Negative expectations mean "not pinned by a literal".
  task automatic do_op(input string nm, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input int e_data, input int e_co, input int e_err, input int e_edges, input int hold);
    int edges;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk); #1;
    edges = 1;
    req_valid = 1'($urandom_range(0, 1));
    req_op = 4'($urandom); req_a = 16'($urandom); req_b = 16'($urandom);
    while (!resp_valid && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    chk({nm, " resp_valid seen"}, resp_valid, 1'b1);
    if (e_edges >= 0) chk({nm, " latency"}, edges, e_edges);
    if (e_data >= 0) chk({nm, " data"}, resp_data, e_data);
    if (e_co >= 0) chk({nm, " co"}, resp_co, e_co);
    if (e_err >= 0) chk({nm, " err"}, resp_err, e_err);
    repeat (hold) begin @(posedge clk); #1; end
    if (hold > 0) begin
      chk({nm, " held valid"}, resp_valid, 1'b1);
      if (e_data >= 0) chk({nm, " held data"}, resp_data, e_data);
      chk({nm, " held req_ready"}, req_ready, 1'b0);
      chk({nm, " held busy"}, busy, 1'b1);
    end
    resp_ready = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk({nm, " idle req_ready"}, req_ready, 1'b1);
    chk({nm, " idle busy"}, busy, 1'b0);
    chk({nm, " idle valid"}, resp_valid, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    req_op = 4'd0; req_a = 16'd0; req_b = 16'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset resp_valid", resp_valid, 1'b0);
    chk("reset resp_data", resp_data, 16'd0);
    chk("reset resp_co", resp_co, 1'b0);
    chk("reset resp_err", resp_err, 1'b0);
    chk("reset req_ready", req_ready, 1'b1);
    chk("reset busy", busy, 1'b0);
    chk_en = 1'b1;

    do_op("add9_8",   4'd0,  16'd9,     16'd8,     17,      0, 0, 2,  0);
    do_op("add_wrap", 4'd0,  16'hFFFE,  16'd2,     0,       1, 0, 2,  0);
    do_op("sub10_4",  4'd1,  16'd10,    16'd4,     6,       1, 0, 2,  0);
    do_op("sra",      4'd11, 16'hFFFC,  16'd7,     'hFFFE,  0, 0, 2,  0);
    do_op("and10_9",  4'd4,  16'd10,    16'd9,     8,       0, 0, 2,  0);
    do_op("inc_max",  4'd5,  16'hFFFF,  16'd3,     0,       1, 0, 2,  0);
    do_op("dec_zero", 4'd6,  16'd0,     16'd3,     'hFFFF,  0, 0, 2,  0);
    do_op("neg1",     4'd8,  16'd1,     16'd3,     'hFFFF,  0, 0, 2,  0);
    do_op("shl",      4'd9,  16'h8001,  16'd3,     2,       1, 0, 2,  0);
    do_op("shr",      4'd10, 16'h8001,  16'd3,     'h4000,  1, 0, 2,  0);
    do_op("not",      4'd7,  16'h00FF,  16'h1234,  'hFF00,  0, 0, 2,  0);
    do_op("mul300_7", 4'd12, 16'd300,   16'd7,     2100,    0, 0, 4,  0);
    do_op("mul256sq", 4'd12, 16'h0100,  16'h0100,  0,       1, 0, 10, 0);
    do_op("mul_b0",   4'd12, 16'd1234,  16'd0,     0,       0, 0, 2,  0);
    do_op("mul_ffff", 4'd12, 16'hFFFF,  16'hFFFF,  1,       1, 0, 17, 0);
    do_op("hold_xor", 4'd2,  16'h0F0F,  16'h00FF,  'h0FF0,  0, 0, 2,  5);
    do_op("illegal",  4'd14, 16'd5,     16'd6,     0,       0, 1, 2,  0);
    do_op("or_after", 4'd3,  16'h1200,  16'h0034,  'h1234,  0, 0, 2,  0);

    for (int op = 0; op < 16; op++) begin
      for (int k = 0; k < 2; k++) begin
        do_op("sweep", 4'(op), 16'($urandom), 16'($urandom), -1, -1, -1, -1, 0);
      end
    end

    // Abort a long multiply in its fifth cycle.
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 4'd12; req_a = 16'd3; req_b = 16'hFFFF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("mid-mul busy", busy, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort req_ready", req_ready, 1'b1);
    chk("abort busy", busy, 1'b0);
    chk("abort resp_valid", resp_valid, 1'b0);
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (resp_valid) seen = 1'b1;
    end
    chk("abort no response", seen, 1'b0);
    do_op("add_after_abort", 4'd0, 16'd100, 16'd23, 123, 0, 0, 2, 0);

    // Reset wins over a simultaneous request.
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 1'b1; req_op = 4'd0; req_a = 16'd1; req_b = 16'd1;
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0;
    chk("rst_vs_req busy", busy, 1'b0);
    chk("rst_vs_req req_ready", req_ready, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    chk("rst_vs_req no response", resp_valid, 1'b0);

    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; all state on rising edge.
REQ-002 SHALL have port: rst  in  1  reset; synchronous, active-high.
REQ-003 SHALL have port: req_valid  in  1  request present.
REQ-004 SHALL have port: req_ready  out  1  controller accepts request.
REQ-005 SHALL have port: req_op  in  4  opcode: 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 INC, 6 DEC, 7 NOT, 8 NEG, 9 SHL, 10 SHR, 11 SRA, 12 MUL, 13-15 illegal.
REQ-006 SHALL have ports: req_a, req_b  in  16 each  operands.
REQ-007 SHALL have port: resp_valid  out  1  result present.
REQ-008 SHALL have port: resp_ready  in  1  consumer takes result.
REQ-009 SHALL have port: resp_data  out  16  result.
REQ-010 SHALL have port: resp_co  out  1  ALU carry-out of final operation.
REQ-011 SHALL have port: resp_err  out  1  illegal opcode.
REQ-012 SHALL have port: busy  out  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, EXEC, MUL, DONE.
REQ-014 SHALL assert req_ready only in IDLE; on req_valid&&req_ready, latch op/a/b and go to MUL if op==12, else EXEC.
REQ-015 SHALL drive the combinational ALU control word {ci,nb,ic,na,xo,no,sr,ss} per op: ADD all 0; SUB ci,nb; XOR ic; OR ic,xo; AND ic,na,nb,no,xo; INC ci (b forced 0); DEC nb (b=0); NOT nb,ic (b=0); NEG ci,na (b=0); SHL all 0 (b=a); SHR sr (b=0); SRA sr,ss (b=0).
REQ-016 SHALL in EXEC register ALU out/co into resp_data/resp_co, then go DONE; single-cycle latency: accept edge T -> resp_valid high after edge T+2.
REQ-017 SHALL for illegal op in EXEC load resp_data=0, resp_co=0, resp_err=1; resp_err=0 for all legal ops.
REQ-018 SHALL for MUL use shift-add: on entry acc=0, mcand=a, mplier=b, count=0; each MUL cycle, if mplier[0] then acc = ALU ADD(acc, mcand) and co captured; mcand<<=1, mplier>>=1, count++ (shifts in registers, not ALU).
REQ-019 SHALL leave MUL to DONE after the cycle where the shifted mplier is 0 or count reaches 15; MUL cycles = max(1, msb_index(b)+1); resp_data = low 16 bits of a*b.
REQ-020 SHALL for MUL report resp_co = OR of all captured ADD carry-outs (wrap indicator, not full overflow).
REQ-021 SHALL in DONE hold resp_valid=1 and resp_data/resp_co/resp_err stable until resp_ready; on resp_valid&&resp_ready go IDLE (no back-to-back accept in the same cycle).
REQ-022 SHALL ignore req_valid and operand changes while not in IDLE.

Reset
REQ-023 SHALL on rst (sampled at clk edge) enter IDLE, clear resp_valid, resp_data, resp_co, resp_err, acc, count; req_ready=1 and busy=0 in the next cycle.
REQ-024 SHALL abort any in-flight EXEC/MUL/DONE on rst with no response emitted; rst overrides simultaneous req_valid.

Structure
REQ-025 SHALL place opcode enum, FSM state enum, control-word struct and opcode->control-word constant table in shared package alu_pkg.
REQ-026 SHALL instantiate the existing ALU once as its only sub-module; operand/control muxing belongs to alu_ctrl.

Verification
REQ-027 ADD a=9 b=8 accepted at T -> resp_valid after T+2, data 17, co 0, err 0.
REQ-028 ADD 65534+2 -> data 0, co 1; SUB 10-4 -> 6; SRA a=0xFFFC -> 0xFFFE; AND 10&9 -> 8.
REQ-029 MUL a=300 b=7 -> 3 MUL cycles, resp_valid after T+4, data 2100; MUL a=0x0100 b=0x0100 -> 9 MUL cycles, data 0, co 1; MUL b=0 -> 1 MUL cycle, data 0.
REQ-030 resp_ready low 5 cycles in DONE -> data held, req_ready 0, busy 1; then one handshake, IDLE next cycle.
REQ-031 rst pulsed mid-MUL (b=0xFFFF, cycle 5) -> IDLE next cycle, resp_valid never asserted; fresh ADD then completes normally.
REQ-032 op=14 -> data 0, co 0, err 1 at T+2; following legal op -> err 0.
